trigger_sched: RTL and testbench
================================

// Module: trigger_sched
// PURPOSE
//  Trigger front-end controller ahead of trigger_mask, in the clk_pix domain. Selects one trigger
//  source (software pulse, line0 or line1), applies edge selection, a glitch filter and a
//  programmable delay, then issues a single-cycle trigger pulse into trigger_mask.
//  Requests that arrive while a trigger is already in flight are dropped and counted.
// PARAMETERS
//  PIX_CLK_FREQ_KHZ   55000   clk frequency in kHz; CNT_1US = PIX_CLK_FREQ_KHZ/1000 cycles per us
// PORTS
//  clk                   in   1   clk_pix, 55MHz
//  reset                 in   1   asynchronous, active-high reset
//  i_stream_enable       in   1   clk domain, stream enable
//  i_acquisition_start   in   1   clk domain, 1 = acquiring
//  i_trigger_mode        in   1   clk domain, 1 = trigger mode, 0 = continuous
//  iv_trigger_source     in   2   0 = software, 1 = line0, 2 = line1, 3 = none
//  i_trigger_activation  in   1   0 = rising edge / high level, 1 = falling edge / low level
//  i_line0               in   1   asynchronous line input
//  i_line1               in   1   asynchronous line input
//  i_soft_trigger        in   1   clk domain, single-cycle software trigger pulse
//  iv_filter_width       in   16  line glitch filter, in clk cycles (0 = no filter)
//  iv_trigger_delay      in   32  trigger delay, in us
//  i_miss_cnt_clr        in   1   clk domain, synchronous clear of ov_trigger_miss_cnt
//  o_trigger             out  1   single-cycle trigger pulse to trigger_mask
//  o_busy                out  1   1 = state != IDLE
//  ov_trigger_miss_cnt   out  16  number of dropped requests, saturating
// BEHAVIOUR
//  - Reset: state IDLE; o_trigger=0, o_busy=0, ov_trigger_miss_cnt=0; all counters and sync
//    flops are cleared.
//  - en = i_stream_enable & i_acquisition_start & i_trigger_mode (combinational).
//  - Lines: each line passes through a 2-flop synchronizer plus one history flop. An active edge
//    is a sync change toward the active level set by i_trigger_activation.
//  - req_sw = i_soft_trigger & (source==0). req_line = active edge on the selected line
//    (source 1 or 2). Source 3 never produces a request.
//  - Leaving IDLE latches source, activation, filter width and delay. Later changes to these
//    inputs do not affect a trigger already in flight.
//  - FSM states and transitions:
//    - IDLE: req_sw -> DELAY. req_line -> FILTER, or DELAY if filter=0.
//    - FILTER: filt_cnt starts at 0 on entry and increments every cycle the synced line stays
//      at the active level.
//      - Line leaves the active level -> IDLE. No trigger, no miss count.
//      - filt_cnt reaches filter-1 -> DELAY. The line has then been active for exactly
//        filter cycles.
//    - DELAY: the 1us prescaler and dly_cnt are cleared on entry. dly_cnt increments on each
//      1us tick. dly_cnt >= delay -> FIRE. With delay=0, the next cycle is FIRE.
//    - FIRE: one cycle, then IDLE. o_trigger = (state==FIRE), registered.
//  - Latency (software source, filter irrelevant): i_soft_trigger sampled at edge k; o_trigger is
//    high during the cycle after edge k+1+D*CNT_1US, i.e. 2+D*CNT_1US cycles after the request.
//  - Miss counting:
//    - A request seen while en=1 and state != IDLE increments ov_trigger_miss_cnt.
//    - The counter saturates at 16'hFFFF.
//    - i_miss_cnt_clr wins over a simultaneous increment (result is 0).
//    - Requests while en=0 are ignored and not counted.
//  - en falling in any state forces IDLE on the next edge: an in-flight trigger is aborted, with
//    no o_trigger and no miss count. While en=0 the FSM stays in IDLE.
//  - At most one o_trigger per FIRE visit. There is never more than one trigger in flight.
//  - Back-to-back: a request in the cycle state returns to IDLE is accepted.
//    A request during FIRE is a miss.
// TESTING
//  - src=0, delay=0: 1-cycle i_soft_trigger -> one o_trigger pulse exactly 2 cycles later;
//    o_busy high 2 cycles.
//  - src=0, delay=3, PIX_CLK_FREQ_KHZ=55000: soft pulse -> o_trigger 2+165=167 cycles later;
//    a 2nd pulse 50 cycles in -> miss_cnt=1, no extra trigger.
//  - src=1, rising, filter=10: line0 high for 6 cycles -> no trigger, miss_cnt unchanged;
//    high for 20 cycles -> exactly one o_trigger.
//  - src=2, falling, filter=0, delay=0: line1 1->0 -> one o_trigger; line1 0->1 -> none;
//    toggling line0 -> none.
//  - delay=10: assert request, drop i_acquisition_start at cycle 100 -> no o_trigger, state IDLE
//    next cycle; assert reset mid-DELAY -> all outputs 0.
//  - Preload miss_cnt to 16'hFFFE via misses: two more misses -> 16'hFFFF and it holds;
//    clr coinciding with a miss -> 0.

Source files
------------

// File: rtl/trigger_sched_if.sv
// rtl/trigger_sched_if.sv - control, line and status bundle for trigger_sched
//
// Purpose: groups every trigger_sched signal except clk/reset.
// master: drives the configuration, line and request inputs, observes the status outputs.
// slave : the trigger_sched side.
//   i_stream_enable, i_acquisition_start, i_trigger_mode : enable terms (en = AND of all three)
//   iv_trigger_source    : 0 software, 1 line0, 2 line1, 3 none
//   i_trigger_activation : 0 rising edge / high level, 1 falling edge / low level
//   i_line0, i_line1     : asynchronous trigger lines
//   i_soft_trigger       : single-cycle software request
//   iv_filter_width      : glitch filter length in clk cycles (0 = off)
//   iv_trigger_delay     : trigger delay in us
//   i_miss_cnt_clr       : synchronous clear of the miss counter
//   o_trigger            : single-cycle trigger pulse
//   o_busy               : a trigger is in flight
//   ov_trigger_miss_cnt  : saturating count of dropped requests
interface trigger_sched_if;
    logic        i_stream_enable;
    logic        i_acquisition_start;
    logic        i_trigger_mode;
    logic [1:0]  iv_trigger_source;
    logic        i_trigger_activation;
    logic        i_line0;
    logic        i_line1;
    logic        i_soft_trigger;
    logic [15:0] iv_filter_width;
    logic [31:0] iv_trigger_delay;
    logic        i_miss_cnt_clr;
    logic        o_trigger;
    logic        o_busy;
    logic [15:0] ov_trigger_miss_cnt;

    modport master (
        output i_stream_enable, i_acquisition_start, i_trigger_mode, iv_trigger_source,
               i_trigger_activation, i_line0, i_line1, i_soft_trigger, iv_filter_width,
               iv_trigger_delay, i_miss_cnt_clr,
        input  o_trigger, o_busy, ov_trigger_miss_cnt
    );

    modport slave (
        input  i_stream_enable, i_acquisition_start, i_trigger_mode, iv_trigger_source,
               i_trigger_activation, i_line0, i_line1, i_soft_trigger, iv_filter_width,
               iv_trigger_delay, i_miss_cnt_clr,
        output o_trigger, o_busy, ov_trigger_miss_cnt
    );
endinterface

// File: rtl/trigger_sched.sv
// rtl/trigger_sched.sv - trigger source select, edge detect, glitch filter, delay and fire
//
// Purpose: picks one trigger source, detects the active edge, filters line glitches, waits the
// programmed delay in microseconds and emits one o_trigger pulse. Requests arriving while a
// trigger is in flight are dropped and counted in a saturating miss counter.
// Ports:
//   clk    : pixel clock
//   reset  : asynchronous, active-high
//   bus    : trigger_sched_if.slave (configuration, lines, requests, status)
module trigger_sched #(
    parameter int PIX_CLK_FREQ_KHZ = 55000
) (
    input logic           clk,
    input logic           reset,
    trigger_sched_if.slave bus
);
    localparam int CNT_1US = PIX_CLK_FREQ_KHZ / 1000;
    localparam int PW      = (CNT_1US > 1) ? $clog2(CNT_1US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CNT_1US - 1);

    typedef enum logic [1:0] {IDLE, FILTER, DELAY, FIRE} state_t;

    state_t        r_state;
    logic [1:0]    r_meta;       // first synchronizer stage, {line1, line0}
    logic [1:0]    r_sync;       // synchronized line levels
    logic [1:0]    r_hist;       // previous synchronized levels for edge detection
    logic          r_line_sel;   // latched line: 0 = line0, 1 = line1
    logic          r_act;        // latched activation
    logic [15:0]   r_filt;       // latched filter width
    logic [31:0]   r_delay;      // latched delay in us
    logic [15:0]   r_filt_cnt;
    logic [PW-1:0] r_pre;
    logic [31:0]   r_dly_cnt;
    logic          r_trigger;
    logic          r_busy;
    logic [15:0]   r_miss_cnt;

    logic       w_en;
    logic [1:0] w_edge;
    logic       w_req_sw;
    logic       w_req_line;
    logic       w_req;
    logic       w_line_active;

    assign w_en = bus.i_stream_enable & bus.i_acquisition_start & bus.i_trigger_mode;

    // Edge toward the currently configured active level on each line.
    assign w_edge = bus.i_trigger_activation ? (~r_sync & r_hist) : (r_sync & ~r_hist);

    assign w_req_sw   = bus.i_soft_trigger & (bus.iv_trigger_source == 2'd0);
    assign w_req_line = ((bus.iv_trigger_source == 2'd1) & w_edge[0]) |
                        ((bus.iv_trigger_source == 2'd2) & w_edge[1]);
    assign w_req      = w_req_sw | w_req_line;

    // Latched line is at its latched active level (high when r_act=0, low when r_act=1).
    assign w_line_active = r_sync[r_line_sel] ^ r_act;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_meta     <= '0;
            r_sync     <= '0;
            r_hist     <= '0;
            r_line_sel <= 1'b0;
            r_act      <= 1'b0;
            r_filt     <= '0;
            r_delay    <= '0;
            r_filt_cnt <= '0;
            r_pre      <= '0;
            r_dly_cnt  <= '0;
            r_trigger  <= 1'b0;
            r_busy     <= 1'b0;
            r_miss_cnt <= '0;
        end else begin
            r_meta    <= {bus.i_line1, bus.i_line0};
            r_sync    <= r_meta;
            r_hist    <= r_sync;
            r_trigger <= 1'b0;

            // Clear has priority over a same-cycle miss.
            if (bus.i_miss_cnt_clr) begin
                r_miss_cnt <= '0;
            end else if (w_en && (r_state != IDLE) && w_req && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end

            // Outputs are registered alongside the state so they track the state being entered.
            if (!w_en) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_req) begin
                            r_line_sel <= (bus.iv_trigger_source == 2'd2);
                            r_act      <= bus.i_trigger_activation;
                            r_filt     <= bus.iv_filter_width;
                            r_delay    <= bus.iv_trigger_delay;
                            r_busy     <= 1'b1;
                            if (w_req_sw || (bus.iv_filter_width == 16'd0)) begin
                                r_state   <= DELAY;
                                r_pre     <= '0;
                                r_dly_cnt <= '0;
                            end else begin
                                r_state    <= FILTER;
                                r_filt_cnt <= '0;
                            end
                        end
                    end
                    FILTER: begin
                        if (!w_line_active) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else if (r_filt_cnt == r_filt - 16'd1) begin
                            r_state   <= DELAY;
                            r_pre     <= '0;
                            r_dly_cnt <= '0;
                        end else begin
                            r_filt_cnt <= r_filt_cnt + 16'd1;
                        end
                    end
                    DELAY: begin
                        if (r_dly_cnt >= r_delay) begin
                            r_state   <= FIRE;
                            r_trigger <= 1'b1;
                        end else if (r_pre == PRE_LAST) begin
                            r_pre     <= '0;
                            r_dly_cnt <= r_dly_cnt + 32'd1;
                        end else begin
                            r_pre <= r_pre + PW'(1);
                        end
                    end
                    FIRE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_trigger           = r_trigger;
    assign bus.o_busy              = r_busy;
    assign bus.ov_trigger_miss_cnt = r_miss_cnt;
endmodule

// File: tb/tb_trigger_sched.sv
// tb/tb_trigger_sched.sv - self-checking bench for trigger_sched
module tb_trigger_sched;
    localparam int KHZ = 55000;
    localparam int CNT = KHZ / 1000;

    logic clk;
    logic rst;
    trigger_sched_if b ();

    trigger_sched #(.PIX_CLK_FREQ_KHZ(KHZ)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_trig = 0;
    int busy_cnt = 0;
    int last_trig_cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (b.o_trigger) begin
            n_trig++;
            last_trig_cyc = cyc;
        end
        if (b.o_busy) busy_cnt++;
    end

    // Behavioural model: phases are idle / filtering / waiting / firing, with the filter and
    // delay expressed as remaining-cycle countdowns (delay = D*CNT+1 cycles of waiting).
    logic [1:0] m_meta, m_sync, m_hist, t_edge;
    int  m_phase, m_fleft, m_wleft, m_line, m_miss;
    logic m_act, t_en, t_sw, t_ln;
    longint m_delay;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_meta = 0; m_sync = 0; m_hist = 0;
            m_phase = 0; m_fleft = 0; m_wleft = 0; m_line = 0; m_miss = 0;
            m_act = 0; m_delay = 0;
        end else begin
            t_en = b.i_stream_enable & b.i_acquisition_start & b.i_trigger_mode;
            for (int i = 0; i < 2; i++)
                t_edge[i] = b.i_trigger_activation ? (!m_sync[i] && m_hist[i])
                                                   : (m_sync[i] && !m_hist[i]);
            t_sw = b.i_soft_trigger && (b.iv_trigger_source == 0);
            t_ln = ((b.iv_trigger_source == 1) && t_edge[0]) ||
                   ((b.iv_trigger_source == 2) && t_edge[1]);
            if (b.i_miss_cnt_clr) m_miss = 0;
            else if (t_en && m_phase != 0 && (t_sw || t_ln) && m_miss < 65535) m_miss++;
            if (!t_en) m_phase = 0;
            else begin
                case (m_phase)
                    0: if (t_sw || t_ln) begin
                        m_line  = (b.iv_trigger_source == 2) ? 1 : 0;
                        m_act   = b.i_trigger_activation;
                        m_delay = longint'(b.iv_trigger_delay);
                        if (t_sw || b.iv_filter_width == 0) begin
                            m_phase = 2;
                            m_wleft = int'(m_delay * CNT + 1);
                        end else begin
                            m_phase = 1;
                            m_fleft = int'(b.iv_filter_width);
                        end
                    end
                    1: if (m_sync[m_line] == m_act) m_phase = 0;
                       else begin
                           m_fleft--;
                           if (m_fleft == 0) begin
                               m_phase = 2;
                               m_wleft = int'(m_delay * CNT + 1);
                           end
                       end
                    2: begin
                        m_wleft--;
                        if (m_wleft == 0) m_phase = 3;
                    end
                    default: m_phase = 0;
                endcase
            end
            m_hist = m_sync;
            m_sync = m_meta;
            m_meta = {b.i_line1, b.i_line0};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_trigger", b.o_trigger, (m_phase == 3));
            chk("cmp_busy", b.o_busy, (m_phase != 0));
            chk("cmp_miss_cnt", b.ov_trigger_miss_cnt, m_miss);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(input int bound, input int t0);
        int n;
        n = 0;
        while (n_trig == t0 && n < bound) begin
            tick();
            n++;
        end
        if (n_trig == t0) begin
            checks++;
            errors++;
            $display("FAIL wait_trig: no o_trigger within %0d cycles", bound);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int t0, b0, k;

    initial begin
        rst = 1'b1;
        b.i_stream_enable = 1; b.i_acquisition_start = 1; b.i_trigger_mode = 1;
        b.iv_trigger_source = 2'd3; b.i_trigger_activation = 0;
        b.i_line0 = 0; b.i_line1 = 0; b.i_soft_trigger = 0;
        b.iv_filter_width = 0; b.iv_trigger_delay = 0; b.i_miss_cnt_clr = 0;
        repeat (3) tick();
        chk("reset_trigger", b.o_trigger, 0);
        chk("reset_busy", b.o_busy, 0);
        chk("reset_miss", b.ov_trigger_miss_cnt, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Software source, delay 0: trigger 2 cycles after the request, busy for 2 cycles.
        b.iv_trigger_source = 0; b.iv_trigger_delay = 0;
        tick();
        t0 = n_trig; b0 = busy_cnt;
        b.i_soft_trigger = 1;
        tick(); k = cyc;
        b.i_soft_trigger = 0;
        wait_trig(20, t0);
        chk("sw_d0_latency", last_trig_cyc - k + 1, 2);
        repeat (5) tick();
        chk("sw_d0_busy_cycles", busy_cnt - b0, 2);
        chk("sw_d0_one_pulse", n_trig - t0, 1);

        // Delay 3us: 167-cycle latency, second request is a miss.
        b.iv_trigger_delay = 3;
        t0 = n_trig;
        b.i_soft_trigger = 1;
        tick(); k = cyc;
        b.i_soft_trigger = 0;
        repeat (49) tick();
        b.i_soft_trigger = 1;
        tick();
        b.i_soft_trigger = 0;
        wait_trig(400, t0);
        chk("sw_d3_latency", last_trig_cyc - k + 1, 167);
        chk("sw_d3_miss", b.ov_trigger_miss_cnt, 1);
        repeat (20) tick();
        chk("sw_d3_one_pulse", n_trig - t0, 1);
        b.i_miss_cnt_clr = 1; tick(); b.i_miss_cnt_clr = 0;
        chk("miss_clr", b.ov_trigger_miss_cnt, 0);

        // Line0 rising, filter 10: short pulse rejected, long pulse fires once.
        b.iv_trigger_source = 1; b.i_trigger_activation = 0;
        b.iv_filter_width = 10; b.iv_trigger_delay = 0;
        repeat (4) tick();
        t0 = n_trig;
        b.i_line0 = 1; repeat (6) tick(); b.i_line0 = 0;
        repeat (20) tick();
        chk("filt_short_none", n_trig - t0, 0);
        chk("filt_short_miss", b.ov_trigger_miss_cnt, 0);
        b.i_line0 = 1; repeat (20) tick(); b.i_line0 = 0;
        repeat (10) tick();
        chk("filt_long_one", n_trig - t0, 1);

        // Line1 falling, no filter: only the 1->0 edge fires, line0 is ignored.
        b.iv_trigger_source = 3;
        b.i_line1 = 1; repeat (5) tick();
        b.iv_trigger_source = 2; b.i_trigger_activation = 1; b.iv_filter_width = 0;
        repeat (2) tick();
        t0 = n_trig;
        b.i_line1 = 0; repeat (10) tick();
        chk("l1_fall_one", n_trig - t0, 1);
        b.i_line1 = 1; repeat (10) tick();
        chk("l1_rise_none", n_trig - t0, 1);
        for (int i = 0; i < 6; i++) begin
            b.i_line0 = ~b.i_line0;
            repeat (4) tick();
        end
        chk("l0_ignored", n_trig - t0, 1);

        // Delay 10us aborted by dropping acquisition.
        b.iv_trigger_source = 0; b.iv_trigger_delay = 10; b.i_line0 = 0;
        repeat (4) tick();
        t0 = n_trig;
        b.i_soft_trigger = 1; tick(); b.i_soft_trigger = 0;
        repeat (99) tick();
        b.i_acquisition_start = 0;
        tick();
        chk("abort_busy", b.o_busy, 0);
        repeat (600) tick();
        chk("abort_no_trig", n_trig - t0, 0);
        b.i_acquisition_start = 1;
        tick();

        // Reset during the delay clears everything.
        b.i_soft_trigger = 1; tick(); b.i_soft_trigger = 0;
        repeat (50) tick();
        b.i_soft_trigger = 1; tick(); b.i_soft_trigger = 0;
        chk("pre_reset_miss", b.ov_trigger_miss_cnt, 1);
        repeat (50) tick();
        rst = 1; #1;
        chk("rst_mid_trigger", b.o_trigger, 0);
        chk("rst_mid_busy", b.o_busy, 0);
        chk("rst_mid_miss", b.ov_trigger_miss_cnt, 0);
        tick();
        rst = 0;
        repeat (700) tick();
        chk("rst_mid_no_trig", n_trig - t0, 0);

        // Miss counter saturation and clear priority.
        b.iv_trigger_delay = 2000;
        b.i_soft_trigger = 1;
        tick();
        repeat (65534) tick();
        chk("sat_fffe", b.ov_trigger_miss_cnt, 16'hFFFE);
        repeat (2) tick();
        chk("sat_ffff", b.ov_trigger_miss_cnt, 16'hFFFF);
        repeat (3) tick();
        chk("sat_hold", b.ov_trigger_miss_cnt, 16'hFFFF);
        b.i_miss_cnt_clr = 1; tick(); b.i_miss_cnt_clr = 0;
        chk("clr_beats_miss", b.ov_trigger_miss_cnt, 0);
        b.i_soft_trigger = 0;
        b.i_acquisition_start = 0; tick(); b.i_acquisition_start = 1;
        tick();

        // Randomized traffic checked cycle by cycle against the model.
        t0 = n_trig;
        for (int i = 0; i < 5000; i++) begin
            if (i % 60 == 0) begin
                b.iv_trigger_source    = 2'($urandom_range(0, 3));
                b.i_trigger_activation = 1'($urandom_range(0, 1));
                b.iv_filter_width      = 16'($urandom_range(0, 6));
                b.iv_trigger_delay     = 32'($urandom_range(0, 1));
            end
            b.i_soft_trigger      = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) b.i_line0 = ~b.i_line0;
            if ($urandom_range(0, 7) == 0) b.i_line1 = ~b.i_line1;
            b.i_acquisition_start = ($urandom_range(0, 199) != 0);
            b.i_miss_cnt_clr      = ($urandom_range(0, 149) == 0);
            tick();
        end
        b.i_soft_trigger = 0; b.i_miss_cnt_clr = 0;
        repeat (200) tick();
        checks++;
        if (n_trig == t0) begin
            errors++;
            $display("FAIL random_activity: got %0d triggers expected > 0", n_trig - t0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
